// File: rtl/fft_core_n.sv
// Radix-2 decimation-in-time FFT over a single shared data memory, followed by a
// magnitude pass over bins 0..N/2-1 and a peak search over the non-DC bins.
module fft_core_n #(
    parameter int LOG2N = 6,
    parameter int IN_W  = 16,
    parameter int INT_W = 24,
    parameter int TW_W  = 16,
    parameter int MAG_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    scale_en,
    output logic [LOG2N-1:0]        sample_addr,
    input  logic signed [IN_W-1:0]  sample_in,
    output logic [LOG2N-2:0]        tw_addr,
    input  logic signed [TW_W-1:0]  tw_re,
    input  logic signed [TW_W-1:0]  tw_im,
    output logic                    busy,
    output logic                    done,
    output logic                    ovf,
    input  logic [LOG2N-2:0]        mag_addr,
    output logic [MAG_W-1:0]        mag_out,
    output logic [LOG2N-2:0]        peak_bin,
    output logic [MAG_W-1:0]        peak_mag
);

    localparam int N    = 1 << LOG2N;
    localparam int HALF = N / 2;
    localparam int PW   = INT_W + TW_W + 1;
    localparam int MW   = (INT_W + 2 > MAG_W) ? INT_W + 2 : MAG_W;

    typedef enum logic [2:0] {IDLE, LOAD, BF_ADDR, BF_EXEC, MAG, DONE} state_t;

    state_t                  state_reg, state_next;
    logic [LOG2N:0]          cnt_reg;
    logic [3:0]              stage_reg;
    logic [LOG2N-2:0]        bf_reg;
    logic                    scale_reg;
    logic [LOG2N-1:0]        p_reg, q_reg;
    logic signed [INT_W-1:0] a_re_reg, a_im_reg, b_re_reg, b_im_reg;
    logic [LOG2N-2:0]        cand_bin_reg;
    logic [MAG_W-1:0]        cand_mag_reg;

    logic signed [INT_W-1:0] re_mem [N];
    logic signed [INT_W-1:0] im_mem [N];
    logic [MAG_W-1:0]        mag_mem [HALF];

    logic                    last_bf;
    logic [LOG2N-1:0]        load_rev, load_wr;
    logic [LOG2N-2:0]        bf_mask, bf_low, bf_high, tw_idx;
    logic [LOG2N-1:0]        p_idx, q_idx;
    logic [3:0]              tw_shift;

    assign last_bf = (stage_reg == 4'(LOG2N - 1)) && (bf_reg == (LOG2N-1)'(HALF - 1));
    assign load_wr = LOG2N'(cnt_reg - (LOG2N+1)'(1));

    // Load order is the bit-reversed load counter, so the transform output lands in natural order.
    generate
        for (genvar gi = 0; gi < LOG2N; gi++) begin : g_rev
            assign load_rev[gi] = cnt_reg[LOG2N-1-gi];
        end
    endgenerate

    assign bf_mask  = (LOG2N-1)'((32'd1 << stage_reg) - 32'd1);
    assign bf_low   = bf_reg & bf_mask;
    assign bf_high  = bf_reg & ~bf_mask;
    assign p_idx    = {bf_high, 1'b0} | {1'b0, bf_low};
    assign q_idx    = p_idx | (LOG2N'(1) << stage_reg);
    assign tw_shift = 4'(LOG2N - 1) - stage_reg;
    assign tw_idx   = bf_low << tw_shift;

    // Butterfly datapath: full-precision complex product, then sum/difference with saturation.
    logic signed [PW-1:0]    prod_re, prod_im;
    logic signed [INT_W:0]   t_re, t_im;
    logic signed [INT_W:0]   bf_raw [4];
    logic signed [INT_W:0]   bf_scl [4];
    logic signed [INT_W-1:0] bf_sat [4];
    logic [3:0]              bf_ovf;

    assign prod_re = PW'(b_re_reg) * PW'(tw_re) - PW'(b_im_reg) * PW'(tw_im);
    assign prod_im = PW'(b_re_reg) * PW'(tw_im) + PW'(b_im_reg) * PW'(tw_re);
    assign t_re    = (INT_W+1)'(prod_re >>> (TW_W - 2));
    assign t_im    = (INT_W+1)'(prod_im >>> (TW_W - 2));

    assign bf_raw[0] = (INT_W+1)'(a_re_reg) + t_re;
    assign bf_raw[1] = (INT_W+1)'(a_im_reg) + t_im;
    assign bf_raw[2] = (INT_W+1)'(a_re_reg) - t_re;
    assign bf_raw[3] = (INT_W+1)'(a_im_reg) - t_im;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sat
            assign bf_scl[gi] = scale_reg ? (bf_raw[gi] >>> 1) : bf_raw[gi];
            assign bf_ovf[gi] = bf_scl[gi][INT_W] ^ bf_scl[gi][INT_W-1];
            assign bf_sat[gi] = bf_ovf[gi] ? {bf_scl[gi][INT_W], {(INT_W-1){~bf_scl[gi][INT_W]}}}
                                           : bf_scl[gi][INT_W-1:0];
        end
    endgenerate

    // Magnitude approximation; one extra bit keeps |most negative| representable.
    logic [LOG2N-2:0]      mag_k;
    logic [LOG2N-1:0]      mag_idx;
    logic signed [INT_W:0] m_re, m_im;
    logic [INT_W:0]        abs_re, abs_im, mag_mx, mag_mn;
    logic [MW-1:0]         mag_sum;
    logic [MAG_W-1:0]      mag_val;

    assign mag_k   = cnt_reg[LOG2N-2:0];
    assign mag_idx = {1'b0, mag_k};
    assign m_re    = (INT_W+1)'(re_mem[mag_idx]);
    assign m_im    = (INT_W+1)'(im_mem[mag_idx]);
    assign abs_re  = m_re[INT_W] ? (INT_W+1)'(-m_re) : (INT_W+1)'(m_re);
    assign abs_im  = m_im[INT_W] ? (INT_W+1)'(-m_im) : (INT_W+1)'(m_im);
    assign mag_mx  = (abs_re > abs_im) ? abs_re : abs_im;
    assign mag_mn  = (abs_re > abs_im) ? abs_im : abs_re;
    assign mag_sum = MW'(mag_mx) + MW'(mag_mn >> 1);
    assign mag_val = (mag_sum > MW'({MAG_W{1'b1}})) ? {MAG_W{1'b1}} : mag_sum[MAG_W-1:0];

    assign mag_out = mag_mem[mag_addr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = LOAD;
            LOAD:    if (cnt_reg == (LOG2N+1)'(N)) state_next = BF_ADDR;
            BF_ADDR: state_next = BF_EXEC;
            BF_EXEC: state_next = last_bf ? MAG : BF_ADDR;
            MAG:     if (cnt_reg == (LOG2N+1)'(HALF - 1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy        = 1'b0;
        done        = 1'b0;
        sample_addr = '0;
        tw_addr     = '0;
        case (state_reg)
            LOAD: begin
                busy = 1'b1;
                if (!cnt_reg[LOG2N]) sample_addr = load_rev;
            end
            BF_ADDR: begin
                busy    = 1'b1;
                tw_addr = tw_idx;
            end
            BF_EXEC, MAG: busy = 1'b1;
            DONE:         done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg      <= '0;
            stage_reg    <= '0;
            bf_reg       <= '0;
            scale_reg    <= 1'b0;
            ovf          <= 1'b0;
            cand_bin_reg <= '0;
            cand_mag_reg <= '0;
            peak_bin     <= '0;
            peak_mag     <= '0;
        end else begin
            case (state_reg)
                IDLE: if (start) begin
                    cnt_reg   <= '0;
                    stage_reg <= '0;
                    bf_reg    <= '0;
                    scale_reg <= scale_en;
                    ovf       <= 1'b0;
                end
                LOAD: cnt_reg <= cnt_reg + (LOG2N+1)'(1);
                BF_EXEC: begin
                    cnt_reg <= '0;
                    ovf     <= ovf | (|bf_ovf);
                    if (bf_reg == (LOG2N-1)'(HALF - 1)) begin
                        bf_reg    <= '0;
                        stage_reg <= stage_reg + 4'd1;
                    end else begin
                        bf_reg <= bf_reg + (LOG2N-1)'(1);
                    end
                end
                MAG: begin
                    cnt_reg <= cnt_reg + (LOG2N+1)'(1);
                    // Bin 1 seeds the search; strict compare keeps the lowest index on ties.
                    if ((mag_k == (LOG2N-1)'(1)) || ((mag_k != '0) && (mag_val > cand_mag_reg))) begin
                        cand_bin_reg <= mag_k;
                        cand_mag_reg <= mag_val;
                    end
                end
                DONE: begin
                    peak_bin <= cand_bin_reg;
                    peak_mag <= cand_mag_reg;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        case (state_reg)
            LOAD: if (cnt_reg != '0) begin
                re_mem[load_wr] <= INT_W'(sample_in);
                im_mem[load_wr] <= '0;
            end
            BF_ADDR: begin
                a_re_reg <= re_mem[p_idx];
                a_im_reg <= im_mem[p_idx];
                b_re_reg <= re_mem[q_idx];
                b_im_reg <= im_mem[q_idx];
                p_reg    <= p_idx;
                q_reg    <= q_idx;
            end
            BF_EXEC: begin
                re_mem[p_reg] <= bf_sat[0];
                im_mem[p_reg] <= bf_sat[1];
                re_mem[q_reg] <= bf_sat[2];
                im_mem[q_reg] <= bf_sat[3];
            end
            MAG: mag_mem[mag_k] <= mag_val;
            default: ;
        endcase
    end

endmodule
